// File: rtl/clock_pkg.sv
// Shared types and widths for the clock-service supervisor.
package clock_pkg;

  typedef enum logic [2:0] {
    RESET_DCM,
    WAIT_LOCK,
    RELEASE,
    RUN,
    FAIL
  } sup_state_e;

  localparam int RETRY_W   = 4;
  localparam int UNLOCK_W  = 16;
  localparam int DOM_IDX_W = 4;

  localparam logic [UNLOCK_W-1:0] UNLOCK_MAX = '1;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous status inputs; resets to 0.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: non-blocking assignments so q takes the previous meta, giving two real stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/clock_supervisor.sv
// DCM reset sequencing, lock qualification with retry/timeout, and staggered
// release of downstream domain resets, all on the reference clock.
module clock_supervisor
  import clock_pkg::*;
#(
  parameter int NDOM         = 4,
  parameter int RST_PULSE    = 3,
  parameter int LOCK_FILTER  = 16,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int MAX_RETRY    = 7,
  parameter int STAGGER      = 8,
  parameter int CW           = 20
) (
  input  logic                clkIn,
  input  logic                rstIn,
  input  logic                dcmLocked,
  input  logic                clkStopped,
  input  logic                swReset,
  output logic                rstDCM,
  output logic [NDOM-1:0]     domRstn,
  output logic                ready,
  output logic                failed,
  output logic [RETRY_W-1:0]  retryCount,
  output logic [UNLOCK_W-1:0] unlockCount
);

  localparam logic [CW-1:0]        PULSE_LAST   = CW'(RST_PULSE - 1);
  localparam logic [CW-1:0]        FILTER_LAST  = CW'(LOCK_FILTER - 1);
  localparam logic [CW-1:0]        TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0]        STAGGER_LAST = CW'(STAGGER - 1);
  localparam logic [RETRY_W-1:0]   RETRY_LAST   = RETRY_W'(MAX_RETRY - 1);
  localparam logic [DOM_IDX_W-1:0] LAST_DOM     = DOM_IDX_W'(NDOM - 1);

  sup_state_e           state;
  logic [CW-1:0]        timer;
  logic [CW-1:0]        filter;
  logic [DOM_IDX_W-1:0] dom_idx;
  logic [DOM_IDX_W-1:0] next_idx;
  logic                 lock_s;
  logic                 stop_s;
  logic                 lock_lost;

  sync2 u_sync_lock (
    .clk (clkIn),
    .rst (rstIn),
    .d   (dcmLocked),
    .q   (lock_s)
  );

  sync2 u_sync_stop (
    .clk (clkIn),
    .rst (rstIn),
    .d   (clkStopped),
    .q   (stop_s)
  );

  assign next_idx  = dom_idx + 1'b1;
  assign lock_lost = ((state == RELEASE) || (state == RUN)) && (!lock_s || stop_s);

  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      state       <= RESET_DCM;
      rstDCM      <= 1'b1;
      domRstn     <= '0;
      ready       <= 1'b0;
      failed      <= 1'b0;
      retryCount  <= '0;
      unlockCount <= '0;
      timer       <= '0;
      filter      <= '0;
      dom_idx     <= '0;
    end else if (swReset) begin
      state      <= RESET_DCM;
      rstDCM     <= 1'b1;
      domRstn    <= '0;
      ready      <= 1'b0;
      failed     <= 1'b0;
      retryCount <= '0;
      timer      <= '0;
      filter     <= '0;
      dom_idx    <= '0;
    end else if (lock_lost) begin
      // Lock loss restarts acquisition but keeps the retry budget as it was.
      state   <= RESET_DCM;
      rstDCM  <= 1'b1;
      domRstn <= '0;
      ready   <= 1'b0;
      timer   <= '0;
      filter  <= '0;
      dom_idx <= '0;
      if (unlockCount != UNLOCK_MAX) unlockCount <= unlockCount + 1'b1;
    end else begin
      case (state)
        RESET_DCM: begin
          if (timer == PULSE_LAST) begin
            state  <= WAIT_LOCK;
            rstDCM <= 1'b0;
            timer  <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        WAIT_LOCK: begin
          filter <= lock_s ? filter + 1'b1 : '0;
          // A timeout on the same edge as filter completion still counts as a failed attempt.
          if (timer == TIMEOUT_LAST) begin
            timer      <= '0;
            filter     <= '0;
            rstDCM     <= 1'b1;
            retryCount <= retryCount + 1'b1;
            if (retryCount == RETRY_LAST) begin
              state  <= FAIL;
              failed <= 1'b1;
            end else begin
              state <= RESET_DCM;
            end
          end else begin
            timer <= timer + 1'b1;
            if (lock_s && (filter == FILTER_LAST)) begin
              timer   <= '0;
              filter  <= '0;
              dom_idx <= '0;
              domRstn <= NDOM'(1);
              if (NDOM == 1) begin
                state      <= RUN;
                ready      <= 1'b1;
                retryCount <= '0;
              end else begin
                state <= RELEASE;
              end
            end
          end
        end

        RELEASE: begin
          if (timer == STAGGER_LAST) begin
            timer   <= '0;
            dom_idx <= next_idx;
            domRstn <= domRstn | (NDOM'(1) << next_idx);
            if (next_idx == LAST_DOM) begin
              state      <= RUN;
              ready      <= 1'b1;
              retryCount <= '0;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

        RUN: begin
          ready <= 1'b1;
        end

        FAIL: begin
          failed  <= 1'b1;
          rstDCM  <= 1'b1;
          domRstn <= '0;
          ready   <= 1'b0;
        end

        default: begin
          state <= RESET_DCM;
        end
      endcase
    end
  end

endmodule

// File: doc/clock_supervisor.md
# clock_supervisor

Parametrised clock-service supervisor running on the board reference clock.
- Sequences the DCM/PLL reset and qualifies lock with a stability filter.
- Retries lock acquisition with a timeout and a bounded retry count.
- Releases NDOM downstream domain resets in a staggered order.
- Counts lock-loss events and reports a hard-fail status.
- Sits between the platform clock primitive and the per-domain reset flops; replaces the fixed 3-cycle unlock pulse scheme of earlier platforms.

## Interface
Parameters:
- NDOM, 4, number of domain reset outputs (1..16)
- RST_PULSE, 3, clkIn cycles rstDCM is held per attempt (≥3)
- LOCK_FILTER, 16, consecutive synced-locked cycles required to declare lock
- LOCK_TIMEOUT, 65536, clkIn cycles allowed per attempt before retry
- MAX_RETRY, 7, failed attempts before entering FAIL (1..15)
- STAGGER, 8, clkIn cycles between successive domain releases (≥1)
- CW, 20, timer width; must satisfy 2^CW > max(LOCK_TIMEOUT, STAGGER, RST_PULSE)

Ports:
- clkIn  in  1  reference clock; sole clock
- rstIn  in  1  asynchronous, active-high reset
- dcmLocked  in  1  DCM LOCKED; asynchronous, synchronised internally
- clkStopped  in  1  DCM STATUS[1] (CLKIN stopped); asynchronous, synchronised internally
- swReset  in  1  synchronous one-cycle restart request
- rstDCM  out  1  DCM reset, active-high, registered
- domRstn  out  NDOM  per-domain active-low reset requests, registered
- ready  out  1  all domains released, lock good
- failed  out  1  retry budget exhausted
- retryCount  out  4  failed attempts in current acquisition
- unlockCount  out  16  lock-loss events since rstIn; saturates at 0xFFFF

## Operation
- Reset values:
  - state = RESET_DCM, rstDCM = 1, domRstn = 0, ready = 0, failed = 0
  - retryCount = 0, unlockCount = 0
  - timer and filter counters = 0
- lockS/stopS: dcmLocked/clkStopped through 2-flop synchronisers (reset to 0).
- FSM:
  - RESET_DCM: rstDCM = 1 for RST_PULSE cycles, then → WAIT_LOCK (rstDCM = 0, timer cleared).
  - WAIT_LOCK: filter counts consecutive lockS = 1 cycles; any lockS = 0 clears it.
    - Filter reaching LOCK_FILTER → RELEASE.
    - Otherwise the timer reaching LOCK_TIMEOUT increments retryCount.
    - If retryCount reaches MAX_RETRY → FAIL, else → RESET_DCM.
  - RELEASE: index i starts at 0. domRstn[i] rises on entry, then each further STAGGER cycles, in ascending order. The edge raising domRstn[NDOM-1] also sets ready = 1 and moves to RUN.
  - RUN: retryCount cleared on entry; ready = 1.
  - FAIL: failed = 1, rstDCM = 1, domRstn = 0, ready = 0. Leaves only on swReset or rstIn.
- Lock loss: lockS = 0 or stopS = 1 while in RELEASE or RUN:
  - domRstn all 0 and ready = 0 on the next edge, with → RESET_DCM.
  - unlockCount increments once per event (saturating).
  - retryCount is unchanged.
- swReset in any state: → RESET_DCM on the next edge, domRstn = 0, ready = 0, failed = 0, retryCount = 0. unlockCount is not incremented.
- Priority on the same cycle: swReset > lock loss > timeout > filter complete.
- rstIn mid-operation forces all reset values immediately (asynchronous).

## Timing
- rstIn deassert → rstDCM high for exactly RST_PULSE edges.
- dcmLocked rise → lockS rise: 2 edges.
- lockS held high → RELEASE entry (domRstn[0] rises) on the LOCK_FILTER-th consecutive high edge.
- domRstn[k] rises k·STAGGER cycles after domRstn[0].
- ready rises with domRstn[NDOM-1], (NDOM-1)·STAGGER cycles after domRstn[0].
- Lock loss → domRstn low: 2 (sync) + 1 edges after dcmLocked falls.
- NDOM = 1: domRstn[0] and ready rise on the same edge.

## Structure
- Shared package clock_pkg:
  - FSM state encoding (RESET_DCM, WAIT_LOCK, RELEASE, RUN, FAIL)
  - retryCount/unlockCount widths
- Sub-module sync2: 2-flop synchroniser with asynchronous active-high reset; instantiated for dcmLocked and clkStopped.
- Per-domain flops in the clock domains themselves remain outside this block.

## Test plan
Defaults, with overrides LOCK_TIMEOUT = 1000 and MAX_RETRY = 3.
- Normal bring-up: release rstIn, raise dcmLocked at cycle 10.
  - rstDCM high cycles 1–3.
  - domRstn[0] rises at cycle 10+2+16.
  - domRstn[1..3] follow at +8, +16, +24.
  - ready rises with domRstn[3]; unlockCount = 0.
- Filter glitch: dcmLocked high 10 cycles, low 1, high → filter restarts; domRstn[0] rises 16 synced cycles after the second rise.
- Timeout/fail: dcmLocked held 0.
  - retryCount steps 1, 2 at ~1003-cycle intervals.
  - Third timeout → failed = 1, rstDCM = 1.
  - swReset → failed = 0, retryCount = 0, new RESET_DCM pulse.
- Lock loss in RUN: drop dcmLocked.
  - All domRstn = 0 and ready = 0 three edges later.
  - unlockCount = 1; re-lock repeats the staggered release.
- Simultaneous swReset and lock loss in RUN → RESET_DCM, unlockCount unchanged.
- Asynchronous rstIn mid-RELEASE (after domRstn[1] rises) → all outputs return to reset values without waiting for a clock edge.
